// File: rtl/pwm_bank.sv
// Bank of NUM_CH PWM channels sharing one prescaler and period counter,
// with a small register file for enables, modes, polarities and duties.
module pwm_bank #(
  parameter int NUM_CH   = 16,
  parameter int DUTY_W   = 8,
  parameter int PRESCALE = 3333
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_addr,
  input  logic [31:0]       wr_data,
  input  logic              rd_en,
  input  logic [7:0]        rd_addr,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  output logic              err,
  output logic [NUM_CH-1:0] pwm_out
);

  localparam int                PRE_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
  localparam logic [DUTY_W-1:0] CNT_LAST  = DUTY_W'((1 << DUTY_W) - 2);
  localparam int                DUTY_BASE = 16;

  logic [NUM_CH-1:0] r_en;
  logic [NUM_CH-1:0] r_mode;
  logic [NUM_CH-1:0] r_pol;
  logic              r_run;
  logic              r_load;
  logic [PRE_W-1:0]  r_pre;
  logic [DUTY_W-1:0] r_cnt;
  logic [DUTY_W-1:0] r_shadow [NUM_CH];
  logic [DUTY_W-1:0] r_active [NUM_CH];

  logic              w_tick;
  logic              w_bound;
  logic              w_copy;
  logic [NUM_CH-1:0] w_wr_sel;
  logic [NUM_CH-1:0] w_rd_sel;
  logic              w_wr_map;
  logic              w_rd_map;
  logic [31:0]       w_rd_val;
  logic [NUM_CH-1:0] w_raw;
  logic              w_unused;

  assign w_unused = &{1'b0, wr_data, 1'b0};

  assign w_tick  = r_run && (r_pre == PRE_LAST);
  assign w_bound = w_tick && (r_cnt == CNT_LAST);
  assign w_copy  = w_bound || r_load;

  always_comb begin
    w_wr_sel = '0;
    w_rd_sel = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_wr_sel[i] = (wr_addr == 8'(DUTY_BASE + i));
      w_rd_sel[i] = (rd_addr == 8'(DUTY_BASE + i));
    end
  end

  assign w_wr_map = (wr_addr <= 8'h03) || (|w_wr_sel);
  assign w_rd_map = (rd_addr <= 8'h03) || (|w_rd_sel);

  // Read mux sees pre-write state, so a same-cycle write/read returns the old value.
  always_comb begin
    w_rd_val = '0;
    case (rd_addr)
      8'h00: w_rd_val[NUM_CH-1:0] = r_en;
      8'h01: w_rd_val[NUM_CH-1:0] = r_mode;
      8'h02: w_rd_val[NUM_CH-1:0] = r_pol;
      8'h03: w_rd_val[0]          = r_run;
      default: begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (w_rd_sel[i]) w_rd_val[DUTY_W-1:0] = r_shadow[i];
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en   <= '0;
      r_mode <= '0;
      r_pol  <= '0;
      r_run  <= 1'b0;
      r_load <= 1'b0;
    end else begin
      r_load <= wr_en && (wr_addr == 8'h03) && wr_data[1];
      if (wr_en) begin
        case (wr_addr)
          8'h00:   r_en   <= wr_data[NUM_CH-1:0];
          8'h01:   r_mode <= wr_data[NUM_CH-1:0];
          8'h02:   r_pol  <= wr_data[NUM_CH-1:0];
          8'h03:   r_run  <= wr_data[0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !r_run) begin
      r_pre <= '0;
      r_cnt <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
      r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // Active copy uses the old shadow even when a duty write lands in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= '{default: '0};
      r_active <= '{default: '0};
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (w_copy) r_active[i] <= r_shadow[i];
        if (wr_en && w_wr_sel[i]) r_shadow[i] <= wr_data[DUTY_W-1:0];
      end
    end
  end

  always_comb begin
    w_raw = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_raw[i] = (r_cnt < r_active[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out  <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      pwm_out  <= r_pol ^ (r_en & (~r_mode | w_raw));
      rd_data  <= rd_en ? w_rd_val : '0;
      rd_valid <= rd_en;
      err      <= (rd_en && !w_rd_map) || (wr_en && !w_wr_map);
    end
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: cycle model compared every negedge plus
// hand-computed literal checks on duty, period, polarity and register access.
module tb_pwm_bank;
  localparam int NUM_CH   = 4;
  localparam int DUTY_W   = 4;
  localparam int PRESCALE = 1;
  localparam int MAX      = (1 << DUTY_W) - 1;
  localparam int MASK     = (1 << DUTY_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [7:0]        wr_addr = '0;
  logic [31:0]       wr_data = '0;
  logic              rd_en = 1'b0;
  logic [7:0]        rd_addr = '0;
  logic [31:0]       rd_data;
  logic              rd_valid;
  logic              err;
  logic [NUM_CH-1:0] pwm_out;

  int n_chk = 0;
  int n_err = 0;

  pwm_bank #(.NUM_CH(NUM_CH), .DUTY_W(DUTY_W), .PRESCALE(PRESCALE)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .err(err), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [NUM_CH-1:0]   m_en, m_mode, m_pol, m_pwm;
  bit                m_run, m_loadp, m_rv, m_err, m_ok;
  int                m_pre, m_cnt;
  int                m_shadow [NUM_CH];
  int                m_active [NUM_CH];
  logic [31:0]       m_rd;
  bit                m_tick, m_lvl;

  function automatic bit m_mapped(input logic [7:0] a);
    return (int'(a) <= 3) || (int'(a) >= 16 && int'(a) < 16 + NUM_CH);
  endfunction

  function automatic logic [31:0] m_reg(input logic [7:0] a);
    int x;
    x = int'(a);
    if (x == 0) return 32'(m_en);
    if (x == 1) return 32'(m_mode);
    if (x == 2) return 32'(m_pol);
    if (x == 3) return 32'(m_run);
    if (x >= 16 && x < 16 + NUM_CH) return 32'(m_shadow[x - 16]);
    return 32'd0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ok = 1'b1;
      m_en = '0; m_mode = '0; m_pol = '0; m_run = 1'b0; m_loadp = 1'b0;
      m_pre = 0; m_cnt = 0; m_pwm = '0; m_rv = 1'b0; m_err = 1'b0; m_rd = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_shadow[i] = 0;
        m_active[i] = 0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_lvl    = m_en[i] && (m_mode[i] ? (m_cnt < m_active[i]) : 1'b1);
        m_pwm[i] = m_pol[i] ^ m_lvl;
      end
      m_rv  = rd_en;
      m_rd  = rd_en ? m_reg(rd_addr) : 32'd0;
      m_err = (rd_en && !m_mapped(rd_addr)) || (wr_en && !m_mapped(wr_addr));
      m_tick = m_run && (m_pre == PRESCALE - 1);
      if ((m_tick && m_cnt == MAX - 1) || m_loadp) m_active = m_shadow;
      m_loadp = wr_en && (wr_addr == 8'h03) && wr_data[1];
      if (!m_run) begin
        m_pre = 0;
        m_cnt = 0;
      end else if (m_tick) begin
        m_pre = 0;
        m_cnt = (m_cnt + 1) % MAX;
      end else begin
        m_pre = m_pre + 1;
      end
      if (wr_en) begin
        if (wr_addr == 8'h00) m_en = wr_data[NUM_CH-1:0];
        else if (wr_addr == 8'h01) m_mode = wr_data[NUM_CH-1:0];
        else if (wr_addr == 8'h02) m_pol = wr_data[NUM_CH-1:0];
        else if (wr_addr == 8'h03) m_run = wr_data[0];
        else if (m_mapped(wr_addr)) m_shadow[int'(wr_addr) - 16] = int'(wr_data) & MASK;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("model pwm_out", 32'(pwm_out), 32'(m_pwm));
      check("model rd_valid", 32'(rd_valid), 32'(m_rv));
      check("model err", 32'(err), 32'(m_err));
      if (m_rv) check("model rd_data", rd_data, m_rd);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic rdreg(input logic [7:0] a, output logic [31:0] d, output logic e);
    rd_en = 1'b1; rd_addr = a;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    d = rd_data;
    e = err;
  endtask

  task automatic count_high(input int ch, input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (pwm_out[ch]) hi++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    n_err++;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    int          hi, prev, first_rise, second_rise, k;
    bit          found;

    // Reset state
    idle(3);
    check("reset pwm_out", 32'(pwm_out), 32'd0);
    check("reset rd_valid", 32'(rd_valid), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset rd_data", rd_data, 32'd0);
    rst = 1'b0;
    idle(1);
    check("post-reset pwm_out", 32'(pwm_out), 32'd0);

    // Duty 5/15 with period 15; upper wr_data bits must be dropped
    wr(8'h10, 32'hABCD_0105);
    wr(8'h03, 32'h2);
    wr(8'h00, 32'h1);
    wr(8'h01, 32'h1);
    wr(8'h03, 32'h1);
    idle(2);
    count_high(0, 30, hi);
    check("duty5 highs in 30", 32'(hi), 32'd10);
    prev = pwm_out[0]; first_rise = -1; second_rise = -1;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk);
      #1;
      if (pwm_out[0] && prev == 0) begin
        if (first_rise < 0) first_rise = i;
        else if (second_rise < 0) second_rise = i;
      end
      prev = pwm_out[0];
    end
    check("period", 32'((first_rise >= 0 && second_rise >= 0) ? second_rise - first_rise : 0), 32'd15);

    // Mid-period shadow update takes effect from the next period
    wr(8'h10, 32'd10);
    rdreg(8'h10, d, e);
    check("shadow readback", d, 32'd10);
    idle(20);
    count_high(0, 30, hi);
    check("duty10 highs in 30", 32'(hi), 32'd20);

    // Duty write on the exact boundary tick
    found = 1'b0;
    for (k = 0; k < 40 && !found; k++) begin
      @(posedge clk);
      #1;
      if (m_cnt == MAX - 1) found = 1'b1;
    end
    check("boundary align found", 32'(found), 32'd1);
    wr(8'h10, 32'd3);
    count_high(0, 15, hi);
    check("boundary old duty", 32'(hi), 32'd10);
    count_high(0, 15, hi);
    check("boundary new duty", 32'(hi), 32'd3);

    // Polarity / static mode / duty extremes
    wr(8'h02, 32'h1);
    wr(8'h00, 32'h0);
    idle(2);
    count_high(0, 16, hi);
    check("pol1 en0 const high", 32'(hi), 32'd16);
    wr(8'h00, 32'h1);
    wr(8'h01, 32'h0);
    idle(2);
    count_high(0, 16, hi);
    check("pol1 static const low", 32'(hi), 32'd0);
    wr(8'h02, 32'h0);
    wr(8'h01, 32'h1);
    wr(8'h10, 32'd0);
    wr(8'h03, 32'h3);
    idle(3);
    count_high(0, 16, hi);
    check("duty0 const low", 32'(hi), 32'd0);
    wr(8'h10, 32'd15);
    wr(8'h03, 32'h3);
    idle(3);
    count_high(0, 16, hi);
    check("duty15 const high", 32'(hi), 32'd16);

    // Unmapped accesses
    rdreg(8'h04, d, e);
    check("unmapped rd data", d, 32'd0);
    check("unmapped rd err", 32'(e), 32'd1);
    idle(1);
    check("err single pulse", 32'(err), 32'd0);
    wr(8'h10 + 8'(NUM_CH), 32'd7);
    check("unmapped wr err", 32'(err), 32'd1);
    idle(1);
    check("unmapped wr err clears", 32'(err), 32'd0);
    rdreg(8'h10, d, e);
    check("duty0 unchanged", d, 32'd15);
    rdreg(8'h03, d, e);
    check("ctrl load reads 0", d, 32'd1);

    // Same-cycle write and read of EN returns the old value
    rd_en = 1'b1; rd_addr = 8'h00;
    wr_en = 1'b1; wr_addr = 8'h00; wr_data = 32'hFFFF_FFF5;
    @(posedge clk);
    #1;
    rd_en = 1'b0; wr_en = 1'b0;
    check("rd during wr old", rd_data, 32'd1);
    rdreg(8'h00, d, e);
    check("en masked write", d, 32'd5);

    // All channels running, then RUN=0 freezes cnt at 0
    wr(8'h11, 32'd1);
    wr(8'h12, 32'd7);
    wr(8'h13, 32'd14);
    wr(8'h03, 32'h3);
    wr(8'h00, 32'hF);
    wr(8'h01, 32'hF);
    wr(8'h02, 32'h8);
    idle(40);
    wr(8'h03, 32'h0);
    idle(5);
    check("run0 cnt0 compare", 32'(pwm_out), 32'h7);
    wr(8'h03, 32'h1);
    idle(7);

    // Mid-period reset with a write and read presented
    rst = 1'b1;
    wr_en = 1'b1; wr_addr = 8'h00; wr_data = 32'hF;
    rd_en = 1'b1; rd_addr = 8'h00;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0;
    check("rst pwm_out", 32'(pwm_out), 32'd0);
    check("rst rd_valid", 32'(rd_valid), 32'd0);
    rst = 1'b0;
    idle(1);
    check("rst+1 pwm_out", 32'(pwm_out), 32'd0);
    check("rst+1 rd_valid", 32'(rd_valid), 32'd0);
    for (int a = 0; a < 4; a++) begin
      rdreg(8'(a), d, e);
      check("post-rst reg", d, 32'd0);
    end
    for (int a = 16; a < 16 + NUM_CH; a++) begin
      rdreg(8'(a), d, e);
      check("post-rst duty", d, 32'd0);
    end
    wr(8'h00, 32'h1);
    wr(8'h01, 32'h1);
    idle(3);
    count_high(0, 10, hi);
    check("post-rst duty0 low", 32'(hi), 32'd0);
    wr(8'h10, 32'd4);
    wr(8'h03, 32'h2);
    idle(3);
    count_high(0, 10, hi);
    check("load with run0 high", 32'(hi), 32'd10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
